// File: rtl/baud_tick_gen.sv
// baud_tick_gen: programmable baud-rate tick generator for a UART.
//   A down-counter reloaded from the active divisor emits rx_tick once per
//   (divisor+1) enabled clocks; every OVERSAMPLE-th rx_tick also emits tx_tick.
//   The divisor is loaded as two bytes: the low byte goes to a shadow register
//   and the high-byte write commits {high, shadow} as the active divisor.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   ioaddr, wr_en     - register select (2'b10 low byte, 2'b11 high byte/commit), write strobe
//   dataIn            - write data byte
//   enable            - count enable; when low, counters freeze and ticks stay low
//   rx_tick, tx_tick  - registered one-clock pulses at the oversampled and bit rates
module baud_tick_gen #(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned OVERSAMPLE = 16,
  parameter logic [15:0] RESET_DIV  = 16'h0028
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] ioaddr,
  input  logic       wr_en,
  input  logic [7:0] dataIn,
  input  logic       enable,
  output logic       rx_tick,
  output logic       tx_tick
);

  localparam int unsigned OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [DIV_W-1:0] RST_DIV = RESET_DIV[DIV_W-1:0];
  localparam logic [7:0] RST_LO = RESET_DIV[7:0];
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       lo_q, lo_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [OS_W-1:0]  os_q, os_d;
  logic             rx_q, rx_d;
  logic             tx_q, tx_d;
  logic             commit_c;
  logic             lo_wr_c;

  assign commit_c = wr_en && (ioaddr == 2'b11);
  assign lo_wr_c  = wr_en && (ioaddr == 2'b10);

  // Next-state logic: a commit outranks counting; enable=0 freezes everything.
  always_comb begin
    div_d = div_q;
    lo_d  = lo_q;
    cnt_d = cnt_q;
    os_d  = os_q;
    rx_d  = 1'b0;
    tx_d  = 1'b0;

    if (lo_wr_c) begin
      lo_d = dataIn;
    end

    if (commit_c) begin
      div_d = DIV_W'({dataIn, lo_q});
      cnt_d = DIV_W'({dataIn, lo_q});
      os_d  = '0;
    end else if (enable) begin
      if (cnt_q == '0) begin
        // Terminal count: reload and pulse; the pulse is visible next cycle.
        cnt_d = div_q;
        rx_d  = 1'b1;
        if (os_q == OS_LAST) begin
          os_d = '0;
          tx_d = 1'b1;
        end else begin
          os_d = OS_W'(os_q + 1'b1);
        end
      end else begin
        cnt_d = DIV_W'(cnt_q - 1'b1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= RST_DIV;
      lo_q  <= RST_LO;
      cnt_q <= RST_DIV;
      os_q  <= '0;
      rx_q  <= 1'b0;
      tx_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_d;
      os_q  <= os_d;
      rx_q  <= rx_d;
      tx_q  <= tx_d;
    end
  end

  assign rx_tick = rx_q;
  assign tx_tick = tx_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Testbench for baud_tick_gen: directed period measurements plus a random
// phase, all checked every cycle against an arithmetic reference model.
module tb_baud_tick_gen;

  localparam int unsigned OS = 16;
  localparam int unsigned BOUND = 3000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic       wr_en = 1'b0;
  logic [7:0] dataIn = 8'h00;
  logic       enable = 1'b0;
  logic       rx_tick;
  logic       tx_tick;

  int total = 0;
  int bad = 0;

  baud_tick_gen #(.DIV_W(16), .OVERSAMPLE(OS), .RESET_DIV(16'h0028)) dut (
    .clk(clk), .rst_n(rst_n), .ioaddr(ioaddr), .wr_en(wr_en),
    .dataIn(dataIn), .enable(enable), .rx_tick(rx_tick), .tx_tick(tx_tick)
  );

  always #5 clk = ~clk;

  // Reference model: n_m counts enabled, non-commit clocks since the last
  // commit/reset. A tick lands whenever n_m is a multiple of (divisor+1);
  // the k-th such tick is also a bit tick when k is a multiple of OS.
  logic [15:0]    div_m = 16'h0028;
  logic [7:0]     lo_m = 8'h28;
  longint unsigned n_m = 0;
  logic           exp_rx = 1'b0;
  logic           exp_tx = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    longint unsigned nn;
    longint unsigned d1;
    if (!rst_n) begin
      div_m  <= 16'h0028;
      lo_m   <= 8'h28;
      n_m    <= 0;
      exp_rx <= 1'b0;
      exp_tx <= 1'b0;
    end else if (wr_en && ioaddr == 2'b11) begin
      div_m  <= {dataIn, lo_m};
      n_m    <= 0;
      exp_rx <= 1'b0;
      exp_tx <= 1'b0;
    end else begin
      if (wr_en && ioaddr == 2'b10) lo_m <= dataIn;
      if (enable) begin
        nn = n_m + 1;
        d1 = longint'(div_m) + 1;
        n_m    <= nn;
        exp_rx <= (nn % d1) == 0;
        exp_tx <= ((nn % d1) == 0) && (((nn / d1) % OS) == 0);
      end else begin
        exp_rx <= 1'b0;
        exp_tx <= 1'b0;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    total++;
    if (rx_tick !== exp_rx) begin
      bad++;
      $display("FAIL model_rx t=%0t got=%b exp=%b", $time, rx_tick, exp_rx);
    end
    total++;
    if (tx_tick !== exp_tx) begin
      bad++;
      $display("FAIL model_tx t=%0t got=%b exp=%b", $time, tx_tick, exp_tx);
    end
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Counts rising edges until rx_tick is seen (sampled on falling edges).
  task automatic wait_rx(output int cyc);
    cyc = 0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      cyc++;
      if (rx_tick) return;
    end
    bad++;
    total++;
    $display("FAIL wait_rx timeout got=%0d exp=tick", cyc);
  endtask

  task automatic wait_tx(output int cyc);
    cyc = 0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      cyc++;
      if (tx_tick) return;
    end
    bad++;
    total++;
    $display("FAIL wait_tx timeout got=%0d exp=tick", cyc);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    ioaddr = a;
    dataIn = d;
    wr_en  = 1'b1;
    @(negedge clk);
    wr_en  = 1'b0;
    ioaddr = 2'b00;
  endtask

  task automatic load(input logic [15:0] d);
    wr(2'b10, d[7:0]);
    wr(2'b11, d[15:8]);
  endtask

  initial begin
    int c, c2, c3;
    int r;
    logic [7:0] rd;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_rx", int'(rx_tick), 0);
    check("reset_tx", int'(tx_tick), 0);

    // Defaults: 41-clock rx period, tx on the 16th rx (656 clocks).
    rst_n  = 1'b1;
    enable = 1'b1;
    wait_rx(c);  check("dflt_first_rx", c, 41);
    wait_rx(c2); check("dflt_rx_period", c2, 41);
    wait_tx(c3); check("dflt_first_tx", c + c2 + c3, 656);
    check("dflt_tx_with_rx", int'(rx_tick), 1);
    wait_tx(c);  check("dflt_tx_period", c, 656);

    // Two-byte load of divisor 5.
    load(16'h0005);
    wait_rx(c);  check("div5_first_rx", c, 6);
    wait_rx(c);  check("div5_rx_period", c, 6);
    wait_tx(c);
    wait_tx(c);  check("div5_tx_period", c, 96);

    // Low byte alone does not change the active divisor.
    load(16'h0028);
    wr(2'b10, 8'h03);
    wait_rx(c);
    wait_rx(c);  check("lo_only_period", c, 41);
    wr(2'b11, 8'h00);
    wait_rx(c);  check("lo_commit_first", c, 4);
    wait_rx(c);  check("lo_commit_period", c, 4);

    // Divisor 0: rx every clock, tx every 16.
    load(16'h0000);
    wait_rx(c);  check("div0_rx", c, 1);
    wait_rx(c);  check("div0_rx_again", c, 1);
    wait_tx(c);
    wait_tx(c);  check("div0_tx_period", c, 16);

    // Enable gating stretches the period by the disabled time.
    load(16'h0028);
    wait_rx(c);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    c2 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rx_tick || tx_tick) c2++;
    end
    check("gated_no_ticks", c2, 0);
    enable = 1'b1;
    wait_rx(c);  check("gated_delay", 20 + 10 + c, 51);

    // Reset mid-operation: outputs drop at once, divisor returns to 0x28.
    load(16'h0005);
    wait_rx(c);
    #1 rst_n = 1'b0;
    #1 check("rst_async_rx", int'(rx_tick), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_rx(c);  check("rst_first_rx", c, 41);

    // Random traffic against the model.
    load(16'h0003);
    for (int i = 0; i < 5000; i++) begin
      r = int'($urandom_range(0, 99));
      rd = 8'($urandom_range(0, 12));
      enable = ($urandom_range(0, 9) != 0);
      if (r < 2) begin
        ioaddr = 2'b11;
        dataIn = ($urandom_range(0, 15) == 0) ? 8'h01 : 8'h00;
        wr_en  = 1'b1;
      end else if (r < 10) begin
        ioaddr = 2'b10;
        dataIn = rd;
        wr_en  = 1'b1;
      end else if (r < 14) begin
        ioaddr = 2'($urandom_range(0, 1));
        dataIn = 8'($urandom);
        wr_en  = 1'b1;
      end else if (r < 18) begin
        ioaddr = 2'($urandom_range(2, 3));
        dataIn = 8'($urandom);
        wr_en  = 1'b0;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16, meaning divisor width in bits, legal range 9..16.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning rx_tick count per tx_tick, legal range 2..32.
REQ-003 SHALL have parameter RESET_DIV, default 16'h0028, meaning divisor value loaded at reset; only the low DIV_W bits are used.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port ioaddr, input, 2, register select: 2'b10 selects divisor low byte, 2'b11 selects divisor high byte, 2'b00 and 2'b01 are ignored.
REQ-007 SHALL have port wr_en, input, 1, write strobe qualifying ioaddr and dataIn.
REQ-008 SHALL have port dataIn, input, 8, write data.
REQ-009 SHALL have port enable, input, 1, count enable.
REQ-010 SHALL have port rx_tick, output, 1, registered one-clock pulse at the oversampled rate.
REQ-011 SHALL have port tx_tick, output, 1, registered one-clock pulse at the bit rate.

Function
REQ-012 SHALL write dataIn into the low shadow register on a clock where wr_en=1 and ioaddr=2'b10; the active divisor SHALL be unchanged.
REQ-013 SHALL commit on a clock where wr_en=1 and ioaddr=2'b11: active divisor = {dataIn, low shadow} truncated to DIV_W bits.
REQ-014 SHALL, on the commit clock, reload the tick counter with the new divisor, clear the oversample counter, and drive rx_tick and tx_tick low on the next cycle.
REQ-015 SHALL ignore writes when wr_en=0 or ioaddr is 2'b00 or 2'b01.
REQ-016 SHALL, while enable=1 and no commit occurs, decrement the tick counter each clock, reloading it with the divisor when it is 0.
REQ-017 SHALL assert rx_tick for exactly one clock, in the cycle after the counter reaches 0; the rx_tick period is exactly divisor+1 clocks.
REQ-018 SHALL make the first rx_tick after a commit or reset occur divisor+1 enabled clocks later.
REQ-019 SHALL treat divisor 0 as legal: rx_tick is high every enabled clock.
REQ-020 SHALL increment the oversample counter on each rx_tick, modulo OVERSAMPLE.
REQ-021 SHALL assert tx_tick in the same cycle as every OVERSAMPLE-th rx_tick; the tx_tick period is OVERSAMPLE*(divisor+1) clocks.
REQ-022 SHALL, while enable=0, freeze both counters, hold rx_tick and tx_tick low, and resume the count from the frozen values when enable returns to 1.
REQ-023 SHALL accept commits while enable=0; the reload per REQ-014 still applies.
REQ-024 SHALL give a commit priority over the enable-driven decrement in the same clock.
REQ-025 SHALL allow a shadow write in the same clock as a tick; that write SHALL NOT disturb tick timing.

Reset
REQ-026 SHALL, on rst_n low, immediately and asynchronously set: active divisor = RESET_DIV, low shadow = RESET_DIV[7:0], tick counter = RESET_DIV, oversample counter = 0, rx_tick = 0, tx_tick = 0.
REQ-027 SHALL, when reset is asserted mid-operation, abort any count in progress, with no tick emitted until the REQ-018 timing elapses after deassertion.
REQ-028 SHALL release reset synchronously in effect: counting starts on the first rising clk edge with rst_n high.

Verification
REQ-029 SHALL verify defaults: reset, enable=1, no writes -> rx_tick every 41 clks; tx_tick every 656 clks, coincident with the 16th rx_tick.
REQ-030 SHALL verify a two-byte load: write 0x05 @2'b10, then 0x00 @2'b11 -> first rx_tick 6 clks after commit, period 6; tx_tick period 96.
REQ-031 SHALL verify low-byte-only write: write 0x03 @2'b10 only -> period stays 41; a later write 0x00 @2'b11 -> period 4.
REQ-032 SHALL verify divisor 0: commit 0x0000 -> rx_tick high every clk; tx_tick every 16 clks.
REQ-033 SHALL verify enable gating: drop enable for 10 clks mid-period at divisor 40 -> no ticks while low; the next rx_tick is delayed by exactly 10 clks.
REQ-034 SHALL verify reset mid-operation: assert rst_n low for 3 clks after loading divisor 5 -> outputs low immediately, divisor back to 0x0028, first rx_tick 41 clks after release.
